// File: rtl/bus_arbiter2_pkg.sv
// Shared bus package: arbiter state encoding, default timeout and the
// request bundle that every master presents to the shared slave.
package bus_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEF = 15;

  typedef struct packed {
    logic        we;
    logic [31:2] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_req_t;

  function automatic arb_state_e gnt_state(input logic idx);
    return idx ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/bus_arbiter2_if.sv
// Two-master / one-slave bus bundle. The slave modport is the arbiter's view
// (it serves the masters); the master modport is the surrounding system's view.
interface bus_arbiter2_if;

  logic        m0_stb_i, m1_stb_i;
  logic        m0_we_i,  m1_we_i;
  logic [31:2] m0_adr_i, m1_adr_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;

  logic        s_stb_o, s_we_o;
  logic [31:2] s_adr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_stb_i, m1_stb_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i, s_dat_i, s_ack_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

  modport master (
    output m0_stb_i, m1_stb_i, m0_we_i, m1_we_i, m0_adr_i, m1_adr_i,
           m0_sel_i, m1_sel_i, m0_dat_i, m1_dat_i, s_dat_i, s_ack_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
           s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

endinterface

// File: rtl/bus_arbiter2_timeout.sv
// Saturating wait counter for a granted transfer; expired is high once the
// count has reached TIMEOUT cycles without an acknowledge.
module arb_timeout
  import bus_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr)              cnt <= '0;
    else if (en && (cnt != LIMIT)) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter in front of a single slave, with a per-grant
// acknowledge timeout that terminates a stalled transfer with an error.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bus_arbiter2_if.slave   bus
);

  arb_state_e state, state_nxt;
  logic       last, last_nxt;
  logic       gidx, granted, expired;

  logic     [1:0]       stb, ack, err;
  bus_req_t [1:0]       req;
  logic     [1:0][31:0] rdat;
  bus_req_t             s_req;
  logic                 s_stb;

  assign stb    = {bus.m1_stb_i, bus.m0_stb_i};
  assign req[0] = '{we: bus.m0_we_i, adr: bus.m0_adr_i, sel: bus.m0_sel_i, dat: bus.m0_dat_i};
  assign req[1] = '{we: bus.m1_we_i, adr: bus.m1_adr_i, sel: bus.m1_sel_i, dat: bus.m1_dat_i};

  assign granted = (state != IDLE);
  assign gidx    = (state == GNT1);

  // Counter is held clear while idle, so every grant starts counting from zero.
  arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (!granted),
    .en      (granted && !bus.s_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    s_stb     = 1'b0;
    s_req     = '0;
    ack       = '0;
    err       = '0;
    rdat      = '0;
    case (state)
      IDLE: begin
        if (stb[0] && stb[1]) state_nxt = gnt_state(!last);
        else if (stb[0])      state_nxt = GNT0;
        else if (stb[1])      state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        s_req       = req[gidx];
        // A timed-out cycle withdraws the strobe unless the slave acks in it.
        s_stb       = stb[gidx] && !(expired && !bus.s_ack_i);
        ack[gidx]   = bus.s_ack_i;
        rdat[gidx]  = bus.s_dat_i;
        if (bus.s_ack_i) begin
          state_nxt = IDLE;
          last_nxt  = gidx;
        end else if (!stb[gidx]) begin
          state_nxt = IDLE;
        end else if (expired) begin
          err[gidx] = 1'b1;
          state_nxt = IDLE;
          last_nxt  = gidx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s_stb_o  = s_stb;
  assign bus.s_we_o   = s_req.we;
  assign bus.s_adr_o  = s_req.adr;
  assign bus.s_sel_o  = s_req.sel;
  assign bus.s_dat_o  = s_req.dat;

  assign bus.m0_ack_o = ack[0];
  assign bus.m1_ack_o = ack[1];
  assign bus.m0_err_o = err[0];
  assign bus.m1_err_o = err[1];
  assign bus.m0_dat_o = rdat[0];
  assign bus.m1_dat_o = rdat[1];

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: reset, single read, alternation, write
// mirroring, timeout, ack-at-timeout, mid-transfer reset and abort.
module tb_bus_arbiter2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bus_arbiter2_if bif();

  bus_arbiter2 #(.TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.m0_stb_i = 0; bif.m0_we_i = 0; bif.m0_adr_i = '0; bif.m0_sel_i = '0; bif.m0_dat_i = '0;
    bif.m1_stb_i = 0; bif.m1_we_i = 0; bif.m1_adr_i = '0; bif.m1_sel_i = '0; bif.m1_dat_i = '0;
    bif.s_ack_i  = 0; bif.s_dat_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    // Idle-side inputs carry junk so any leak into the outputs shows up.
    bif.m0_adr_i = 30'h3FFF_FFFF; bif.m0_sel_i = 4'hF; bif.m0_dat_i = 32'h1234_5678;
    bif.m1_adr_i = 30'h2AAA_AAAA; bif.m1_we_i = 1;    bif.m1_dat_i = 32'h8765_4321;
    bif.s_dat_i  = 32'hFFFF_FFFF; bif.s_ack_i = 1;
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    checks++;
    if ({bif.s_stb_o, bif.s_we_o, bif.m0_ack_o, bif.m1_ack_o, bif.m0_err_o, bif.m1_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bif.s_stb_o, bif.s_we_o, bif.m0_ack_o, bif.m1_ack_o, bif.m0_err_o, bif.m1_err_o});
    end
    checks++;
    if ({bif.s_adr_o, bif.s_sel_o, bif.s_dat_o, bif.m0_dat_o, bif.m1_dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got adr %h sel %h sdat %h m0dat %h m1dat %h want all 0",
               bif.s_adr_o, bif.s_sel_o, bif.s_dat_o, bif.m0_dat_o, bif.m1_dat_o);
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    bif.m0_stb_i = 1; bif.m0_we_i = 0; bif.m0_adr_i = 30'h1; bif.m0_sel_i = 4'hF;
    bif.s_dat_i  = 32'h0305_1996; bif.s_ack_i = 1;
    #1;
    checks++;
    if (bif.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL read_idle_stb: got %b want 0", bif.s_stb_o);
    end
    tick();
    checks++;
    if (bif.s_stb_o !== 1'b1 || bif.s_adr_o !== 30'h1 || bif.s_we_o !== 1'b0) begin
      errors++; $display("FAIL read_req: got stb %b adr %h we %b want 1 1 0", bif.s_stb_o, bif.s_adr_o, bif.s_we_o);
    end
    checks++;
    if (bif.m0_ack_o !== 1'b1 || bif.m0_dat_o !== 32'h0305_1996) begin
      errors++; $display("FAIL read_ack: got ack %b dat %h want 1 03051996", bif.m0_ack_o, bif.m0_dat_o);
    end
    checks++;
    if ({bif.m1_ack_o, bif.m1_err_o, bif.m1_dat_o} !== 34'b0) begin
      errors++; $display("FAIL read_m1_quiet: got ack %b err %b dat %h want 0", bif.m1_ack_o, bif.m1_err_o, bif.m1_dat_o);
    end
    tick();
    bif.m0_stb_i = 0;
    #1;
    checks++;
    if (bif.s_stb_o !== 1'b0 || bif.m0_ack_o !== 1'b0) begin
      errors++; $display("FAIL read_back_idle: got stb %b ack %b want 0 0", bif.s_stb_o, bif.m0_ack_o);
    end
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_ack [8];
    int n0 = 0, n1 = 0;
    exp_ack = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    rst = 1; tick(); rst = 0;
    bif.m0_stb_i = 1; bif.m1_stb_i = 1; bif.s_ack_i = 1;
    bif.m0_adr_i = 30'h10; bif.m1_adr_i = 30'h20;
    for (int i = 0; i < 8; i++) begin
      tick();
      n0 += int'(bif.m0_ack_o);
      n1 += int'(bif.m1_ack_o);
      checks++;
      if ({bif.m1_ack_o, bif.m0_ack_o} !== exp_ack[i]) begin
        errors++; $display("FAIL alt_cycle%0d: got acks m1m0=%b want %b", i, {bif.m1_ack_o, bif.m0_ack_o}, exp_ack[i]);
      end
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++; $display("FAIL alt_totals: got m0 %0d m1 %0d want 2 2", n0, n1);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    bif.m1_stb_i = 1; bif.m1_we_i = 1; bif.m1_adr_i = 30'h0ABC;
    bif.m1_sel_i = 4'b0011; bif.m1_dat_i = 32'hDEAD_BEEF;
    bif.m0_adr_i = 30'h0555; bif.m0_dat_i = 32'h1111_1111;
    tick();
    checks++;
    if (bif.s_stb_o !== 1'b1 || bif.s_we_o !== 1'b1 || bif.s_sel_o !== 4'b0011 ||
        bif.s_dat_o !== 32'hDEAD_BEEF || bif.s_adr_o !== 30'h0ABC) begin
      errors++; $display("FAIL write_mirror: got stb %b we %b sel %b dat %h adr %h want 1 1 0011 deadbeef 0abc",
                         bif.s_stb_o, bif.s_we_o, bif.s_sel_o, bif.s_dat_o, bif.s_adr_o);
    end
    checks++;
    if ({bif.m0_ack_o, bif.m0_err_o, bif.m1_ack_o} !== 3'b0) begin
      errors++; $display("FAIL write_wait: got m0ack %b m0err %b m1ack %b want 0 0 0", bif.m0_ack_o, bif.m0_err_o, bif.m1_ack_o);
    end
    bif.s_ack_i = 1;
    #1;
    checks++;
    if (bif.m1_ack_o !== 1'b1 || bif.m0_ack_o !== 1'b0 || bif.m0_err_o !== 1'b0) begin
      errors++; $display("FAIL write_ack: got m1ack %b m0ack %b m0err %b want 1 0 0", bif.m1_ack_o, bif.m0_ack_o, bif.m0_err_o);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bif.s_stb_o !== 1'b0) begin
      errors++; $display("FAIL write_done: got stb %b want 0", bif.s_stb_o);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    bif.m0_stb_i = 1; bif.m0_adr_i = 30'h77;
    tick();
    for (int c = 1; c <= 16; c++) begin
      pulses += int'(bif.m0_err_o);
      checks++;
      if (bif.m0_err_o !== (c == 16) || bif.s_stb_o !== (c != 16)) begin
        errors++; $display("FAIL timeout_c%0d: got err %b stb %b want %b %b",
                           c, bif.m0_err_o, bif.s_stb_o, c == 16, c != 16);
      end
      if (c < 16) tick();
    end
    tick();
    bif.m0_stb_i = 0;
    #1;
    pulses += int'(bif.m0_err_o);
    checks++;
    if (bif.s_stb_o !== 1'b0 || pulses != 1) begin
      errors++; $display("FAIL timeout_after: got stb %b pulses %0d want 0 1", bif.s_stb_o, pulses);
    end
    clear_inputs();
  endtask

  task automatic test_ack_at_timeout();
    bif.m0_stb_i = 1; bif.m0_adr_i = 30'h99;
    tick();
    for (int c = 1; c < 16; c++) tick();
    bif.s_ack_i = 1; bif.s_dat_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bif.m0_ack_o !== 1'b1 || bif.m0_err_o !== 1'b0 || bif.s_stb_o !== 1'b1) begin
      errors++; $display("FAIL ack_at_timeout: got ack %b err %b stb %b want 1 0 1", bif.m0_ack_o, bif.m0_err_o, bif.s_stb_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    bif.m1_stb_i = 1; bif.m1_adr_i = 30'h222; bif.m0_adr_i = 30'h111;
    tick();
    checks++;
    if (bif.s_stb_o !== 1'b1 || bif.s_adr_o !== 30'h222) begin
      errors++; $display("FAIL rstmid_grant1: got stb %b adr %h want 1 222", bif.s_stb_o, bif.s_adr_o);
    end
    rst = 1; bif.m0_stb_i = 1;
    tick();
    rst = 0;
    checks++;
    if (bif.s_stb_o !== 1'b0 || bif.m1_ack_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got stb %b m1ack %b want 0 0", bif.s_stb_o, bif.m1_ack_o);
    end
    tick();
    checks++;
    if (bif.s_stb_o !== 1'b1 || bif.s_adr_o !== 30'h111) begin
      errors++; $display("FAIL rstmid_m0_wins: got stb %b adr %h want 1 111", bif.s_stb_o, bif.s_adr_o);
    end
    bif.s_ack_i = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_abort();
    bif.m1_stb_i = 1; bif.m1_adr_i = 30'h333; bif.m0_adr_i = 30'h444;
    tick();
    bif.m1_stb_i = 0;
    #1;
    checks++;
    if ({bif.s_stb_o, bif.m1_ack_o, bif.m1_err_o} !== 3'b0) begin
      errors++; $display("FAIL abort_quiet: got stb %b ack %b err %b want 0 0 0", bif.s_stb_o, bif.m1_ack_o, bif.m1_err_o);
    end
    tick();
    bif.m0_stb_i = 1; bif.m1_stb_i = 1;
    tick();
    checks++;
    if (bif.s_adr_o !== 30'h333 || bif.s_stb_o !== 1'b1) begin
      errors++; $display("FAIL abort_last_kept: got adr %h stb %b want 333 1", bif.s_adr_o, bif.s_stb_o);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
